load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Initiator side of the data-memory port. Accepts one load/store request per handshake from the
//  execute stage and performs the RV32I byte/half/word access on the word-addressed data memory.
//  Builds byte enables and replicated store data, sign/zero-extends load data, and reports faults
//  (misaligned, illegal funct3, out-of-bounds) without touching memory.
//  Fixed-latency memory; one outstanding request.
// PARAMETERS
//  MEM_BYTES  1024  data memory size in bytes; addr >= MEM_BYTES is a bounds fault
//  MEM_LAT    1     cycles from mem_en to mem_rdata valid (>=1)
// PORTS
//  clk            in   1   single clock, all state on posedge
//  rst            in   1   asynchronous, active-high reset
//  req_valid      in   1   request present
//  req_ready      out  1   unit can accept a request (IDLE and rst low)
//  req_store      in   1   1=store, 0=load
//  req_funct3     in   3   RV32I width/sign code
//  req_addr       in   32  byte address
//  req_wdata      in   32  store data (low bits used for SB/SH)
//  resp_valid     out  1   one-cycle response pulse
//  resp_rdata     out  32  extended load data (0 for stores/faults)
//  resp_err       out  2   00 ok, 01 misaligned, 10 illegal funct3, 11 out of bounds
//  mem_en         out  1   memory access strobe
//  mem_we         out  1   write strobe (only with mem_en)
//  mem_be         out  4   byte enables, bit i = byte lane i
//  mem_addr       out  32  word-aligned address {addr[31:2],2'b00}
//  mem_wdata      out  32  lane-replicated store data
//  mem_rdata      in   32  read word, valid MEM_LAT cycles after mem_en
// BEHAVIOUR
//  Reset: state IDLE, latency counter 0, all outputs 0 (req_ready 0 while rst high). Reset is
//   async; asserting it in any state drops mem_en/mem_we the same instant; no partial write completes.
//  Accept: req_valid & req_ready at a posedge latches store, funct3, addr, wdata.
//  Fault check at accept, priority: illegal funct3 > misaligned > bounds.
//   Legal loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; legal stores 000 SB, 001 SH, 010 SW.
//   Misaligned: half with addr[0]=1, word with addr[1:0]!=0. Bounds: addr > MEM_BYTES-1.
//  FSM states: IDLE, ACCESS, WAIT, RESP.
//   IDLE -> RESP on accept with fault; IDLE -> ACCESS on clean accept.
//   ACCESS: mem_en=1 for exactly one cycle; mem_we=req_store.
//    Store -> RESP. Load -> WAIT, counter loaded with MEM_LAT.
//   WAIT: counter decrements; on the last WAIT cycle mem_rdata is captured and extended -> RESP.
//   RESP: resp_valid=1 for one cycle, resp_rdata/resp_err stable -> IDLE. req_ready=0 outside IDLE.
//  Latency from accept edge to resp_valid: load 2+MEM_LAT cycles, store 2, fault 1.
//   No back-to-back accept in the resp_valid cycle.
//  mem_be: SB 0001<<a[1:0]; SH 0011<<a[1:0]; SW 1111; loads 1111.
//  mem_wdata: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
//  Load extract: byte = rdata[8*a[1:0]+:8], half = rdata[16*a[1]+:16].
//   LB/LH sign-extend; LBU/LHU zero-extend to 32.
//  mem_en, mem_we, mem_be, mem_addr and mem_wdata are 0 in all states except ACCESS.
//  req_* changes while busy are ignored (latched copy used).
// TESTING
//  SW addr 0x10 data 0xDEADBEEF -> ACCESS: mem_we=1, be=1111, mem_addr=0x10; resp_valid 2 cycles after accept, err=00.
//  SB addr 0x13 data 0x000000A5 -> be=1000, mem_wdata=0xA5A5A5A5; then LB 0x13 -> rdata 0xFFFFFFA5, LBU -> 0x000000A5.
//  LH addr 0x12 on word 0x8001_1234 -> 0xFFFF8001; LHU -> 0x00008001; resp at accept+3 (MEM_LAT=1).
//  LW addr 0x06 -> err=01, no mem_en ever; LW 0x400 -> err=11; funct3=011 -> err=10; each resp at accept+1.
//  Assert rst during ACCESS of SW -> mem_we drops immediately, memory word unchanged, state IDLE, outputs 0.
//  MEM_LAT=3 regression: LW resp_valid exactly 5 cycles after accept; req_ready low throughout.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I load/store initiator for a word-addressed, fixed-latency data memory.
// One outstanding request; faults are reported without issuing a memory access.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned MEM_LAT   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CntW = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {StIdle, StAccess, StWait, StResp} state_t;

  state_t          state_q, state_d;
  logic            store_q, store_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [1:0]      err_q, err_d;

  logic        legal, misal, oob;
  logic [1:0]  fault_err;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic        access;

  // Fault classification of the incoming request, highest priority first.
  always_comb begin
    if (req_store) legal = req_funct3 inside {3'b000, 3'b001, 3'b010};
    else           legal = req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    misal = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
            ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    oob   = req_addr >= 32'(MEM_BYTES);
    if (!legal)     fault_err = 2'b10;
    else if (misal) fault_err = 2'b01;
    else if (oob)   fault_err = 2'b11;
    else            fault_err = 2'b00;
  end

  always_comb begin
    ld_byte = mem_rdata[8*addr_q[1:0] +: 8];
    ld_half = mem_rdata[16*addr_q[1] +: 16];
    case (funct3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'h0, ld_byte};
      3'b101:  ld_ext = {16'h0, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    store_d  = store_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          store_d  = req_store;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          rdata_d  = 32'h0;
          err_d    = fault_err;
          state_d  = (fault_err != 2'b00) ? StResp : StAccess;
        end
      end
      StAccess: begin
        if (store_q) begin
          state_d = StResp;
        end else begin
          cnt_d   = CntW'(MEM_LAT);
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == CntW'(1)) begin
          rdata_d = ld_ext;
          cnt_d   = '0;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StResp: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      store_q  <= 1'b0;
      funct3_q <= 3'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      cnt_q    <= '0;
      rdata_q  <= 32'h0;
      err_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      store_q  <= store_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Memory-side outputs are decoded from state so an async reset drops them at once.
  always_comb begin
    access     = (state_q == StAccess);
    req_ready  = (state_q == StIdle) && !rst;
    resp_valid = (state_q == StResp);
    resp_rdata = resp_valid ? rdata_q : 32'h0;
    resp_err   = resp_valid ? err_q : 2'b00;
    mem_en     = access;
    mem_we     = access && store_q;
    mem_addr   = access ? {addr_q[31:2], 2'b00} : 32'h0;
    mem_be     = 4'b0000;
    mem_wdata  = 32'h0;
    if (access) begin
      if (store_q) begin
        case (funct3_q[1:0])
          2'b00: begin
            mem_be    = 4'b0001 << addr_q[1:0];
            mem_wdata = {4{wdata_q[7:0]}};
          end
          2'b01: begin
            mem_be    = 4'b0011 << addr_q[1:0];
            mem_wdata = {2{wdata_q[15:0]}};
          end
          default: begin
            mem_be    = 4'b1111;
            mem_wdata = wdata_q;
          end
        endcase
      end else begin
        mem_be = 4'b1111;
      end
    end
  end

endmodule
